// File: rtl/mmio_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mmio_pkg : window offsets, STATUS/CTRL bit positions, access-FSM states   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package mmio_pkg;

  localparam logic [1:0] OFF_DATA    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CTRL    = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_IRQ      = 6;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_CLR   = 7;

  typedef enum logic [0:0] {
    ACC_IDLE   = 1'b0,
    ACC_ACTIVE = 1'b1
  } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/mmio_responder_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mmio_responder_if : CPU bus strobes/address plus TX/RX stream handshakes  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface mmio_responder_if #(
  parameter int A_WIDTH = 5,
  parameter int WIDTH   = 8
) ();

  logic               rd;
  logic               wr;
  logic [A_WIDTH-1:0] addr;
  logic               hit;
  logic               tx_valid;
  logic [WIDTH-1:0]   tx_data;
  logic               tx_ready;
  logic               rx_valid;
  logic [WIDTH-1:0]   rx_data;
  logic               rx_ready;

  modport slave (
    input  rd, wr, addr, tx_ready, rx_valid, rx_data,
    output hit, tx_valid, tx_data, rx_ready
  );

  modport master (
    output rd, wr, addr, tx_ready, rx_valid, rx_data,
    input  hit, tx_valid, tx_data, rx_ready
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, power-of-two DEPTH, registered occupancy   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int                c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guards use the registered count, so a push while full is dropped even if
  // a pop happens in the same cycle.
  assign w_push = i_push && (r_count != c_FULL);
  assign w_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mmio_responder : 4-register MMIO window bridging CPU bus to TX/RX FIFOs.  |
// | Optional interrupt logic under macro MMIO_IRQ_EN.  Rev 1.0                |
// +---------------------------------------------------------------------------+
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int                 A_WIDTH = 5,
  parameter int                 WIDTH   = 8,
  parameter logic [A_WIDTH-1:0] BASE    = 5'h1C,
  parameter int                 DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mmio_responder_if.slave  bus,
  inout  wire [WIDTH-1:0]  data,
  output logic             irq
);

  localparam int              c_CW   = $clog2(DEPTH) + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  acc_state_t       r_rd_state;
  acc_state_t       w_rd_state_nxt;
  acc_state_t       r_wr_state;
  acc_state_t       w_wr_state_nxt;
  logic             w_rd_start;
  logic             w_rd_end;
  logic             w_wr_start;
  logic             w_hit;
  logic             w_rd_eff;
  logic [1:0]       w_off;
  logic [1:0]       w_rd_sel;
  logic [1:0]       r_rd_off;
  logic             r_rd_udf;
  logic             r_rd_abort;

  logic [WIDTH-1:0] r_scratch;
  logic             r_tx_ovf;
  logic             r_rx_udf;
  logic [WIDTH-1:0] w_ctrl_rd;
  logic             w_irq_bit;
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_rdata;
  logic             w_drive;

  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic [c_CW-1:0]  w_tx_count;
  logic [WIDTH-1:0] w_tx_head;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_rx_ready;
  logic [c_CW-1:0]  w_rx_count;
  logic [WIDTH-1:0] w_rx_head;

  assign w_hit    = (bus.addr[A_WIDTH-1:2] == BASE[A_WIDTH-1:2]);
  assign w_off    = bus.addr[1:0];
  assign w_rd_eff = bus.rd && !bus.wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= ACC_IDLE;
      r_wr_state <= ACC_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_wr_state_nxt = r_wr_state;
    w_rd_start     = 1'b0;
    w_rd_end       = 1'b0;
    w_wr_start     = 1'b0;
    case (r_wr_state)
      ACC_IDLE:   if (bus.wr && w_hit) begin
                    w_wr_state_nxt = ACC_ACTIVE;
                    w_wr_start     = 1'b1;
                  end
      ACC_ACTIVE: if (!bus.wr) w_wr_state_nxt = ACC_IDLE;
      default:    w_wr_state_nxt = ACC_IDLE;
    endcase
    case (r_rd_state)
      ACC_IDLE:   if (w_rd_eff && w_hit) begin
                    w_rd_state_nxt = ACC_ACTIVE;
                    w_rd_start     = 1'b1;
                  end
      ACC_ACTIVE: if (!bus.rd) begin
                    w_rd_state_nxt = ACC_IDLE;
                    w_rd_end       = 1'b1;
                  end
      default:    w_rd_state_nxt = ACC_IDLE;
    endcase
  end

  // The pop is deferred to the falling edge of rd so the head stays on the
  // bus for the whole strobe; an underflow read or a colliding wr cancels it.
  assign w_rx_pop  = w_rd_end && (r_rd_off == OFF_DATA) && !r_rd_udf && !r_rd_abort;
  assign w_tx_push = w_wr_start && (w_off == OFF_DATA) && (w_tx_count != c_FULL);
  assign w_tx_pop  = !w_tx_empty && bus.tx_ready;
  assign w_rx_ready = (w_rx_count != c_FULL);
  assign w_rx_push = bus.rx_valid && w_rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_off   <= OFF_DATA;
      r_rd_udf   <= 1'b0;
      r_rd_abort <= 1'b0;
      r_scratch  <= '0;
      r_tx_ovf   <= 1'b0;
      r_rx_udf   <= 1'b0;
    end else begin
      if (w_rd_start) begin
        r_rd_off   <= w_off;
        r_rd_udf   <= (w_off == OFF_DATA) && w_rx_empty;
        r_rd_abort <= 1'b0;
        if ((w_off == OFF_DATA) && w_rx_empty) r_rx_udf <= 1'b1;
      end else if ((r_rd_state == ACC_ACTIVE) && bus.wr) begin
        r_rd_abort <= 1'b1;
      end
      if (w_wr_start) begin
        case (w_off)
          OFF_DATA:    if (w_tx_count == c_FULL) r_tx_ovf <= 1'b1;
          OFF_CTRL:    if (data[CTRL_CLR]) begin
                         r_tx_ovf <= 1'b0;
                         r_rx_udf <= 1'b0;
                       end
          OFF_SCRATCH: r_scratch <= data;
          default:     ;
        endcase
      end
    end
  end

`ifdef MMIO_IRQ_EN
  logic [1:0] r_ctrl;
  logic       r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_start && (w_off == OFF_CTRL)) begin
        r_ctrl <= {data[CTRL_TX_IE], data[CTRL_RX_IE]};
      end
      r_irq <= (r_ctrl[CTRL_RX_IE] && !w_rx_empty) || (r_ctrl[CTRL_TX_IE] && w_tx_empty);
    end
  end

  assign w_ctrl_rd = {{(WIDTH-2){1'b0}}, r_ctrl};
  assign w_irq_bit = r_irq;
`else
  assign w_ctrl_rd = '0;
  assign w_irq_bit = 1'b0;
`endif

  assign irq = w_irq_bit;

  // Once a read is active it stays bound to the offset latched at entry.
  assign w_rd_sel = (r_rd_state == ACC_ACTIVE) ? r_rd_off : w_off;

  always_comb begin
    w_status              = '0;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_UDF]   = r_rx_udf;
    w_status[ST_IRQ]      = w_irq_bit;
    case (w_rd_sel)
      OFF_DATA:    w_rdata = w_rx_empty ? '0 : w_rx_head;
      OFF_STATUS:  w_rdata = w_status;
      OFF_CTRL:    w_rdata = w_ctrl_rd;
      OFF_SCRATCH: w_rdata = r_scratch;
      default:     w_rdata = '0;
    endcase
  end

  assign w_drive = w_rd_eff && w_hit;
  assign data    = w_drive ? w_rdata : {WIDTH{1'bz}};

  assign bus.hit      = w_hit;
  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = w_tx_head;
  assign bus.rx_ready = w_rx_ready;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  (data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (bus.rx_data),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mmio_responder : directed vector table plus a reset-during-read case   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_mmio_responder;

`ifdef MMIO_IRQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rd, wr;
    logic [4:0] addr;
    logic       oe;
    logic [7:0] dout;
    logic       txr, rxv;
    logic [7:0] rxd;
    logic       chk_d;
    logic [7:0] exp_d;
    logic       exp_hit, exp_txv;
    logic [7:0] exp_txd;
    logic       exp_rxr, exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       irq;
  logic       cpu_oe;
  logic [7:0] cpu_do;
  wire  [7:0] data;
  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       vecs[$];

  mmio_responder_if #(.A_WIDTH(5), .WIDTH(8)) bus ();

  // The bench stands in for the CPU: it drives data on writes, and drives 0
  // where the responder must stay off the bus so a stray drive shows up.
  assign data = cpu_oe ? cpu_do : 8'hzz;

  mmio_responder dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .data (data),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic rd, input logic wr, input logic [4:0] a,
                     input logic oe, input logic [7:0] dout, input logic txr, input logic rxv,
                     input logic [7:0] rxd, input logic cd, input logic [7:0] ed, input logic eh,
                     input logic etv, input logic [7:0] etd, input logic err, input logic ei);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.addr = a; v.oe = oe; v.dout = dout;
    v.txr = txr; v.rxv = rxv; v.rxd = rxd; v.chk_d = cd; v.exp_d = ed;
    v.exp_hit = eh; v.exp_txv = etv; v.exp_txd = etd; v.exp_rxr = err; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.rd = v.rd; bus.wr = v.wr; bus.addr = v.addr;
    cpu_oe = v.oe; cpu_do = v.dout;
    bus.tx_ready = v.txr; bus.rx_valid = v.rxv; bus.rx_data = v.rxd;
    #1;
    if (v.chk_d) chk({v.name, ".data"}, data, v.exp_d);
    chk({v.name, ".hit"}, {7'd0, bus.hit}, {7'd0, v.exp_hit});
    chk({v.name, ".tx_valid"}, {7'd0, bus.tx_valid}, {7'd0, v.exp_txv});
    if (v.exp_txv) chk({v.name, ".tx_data"}, bus.tx_data, v.exp_txd);
    chk({v.name, ".rx_ready"}, {7'd0, bus.rx_ready}, {7'd0, v.exp_rxr});
    chk({v.name, ".irq"}, {7'd0, irq}, {7'd0, v.exp_irq});
    tick();
  endtask

  initial begin
    logic [7:0] st_irq;
    logic [7:0] ctrl_rb;
    st_irq  = EN ? 8'h64 : 8'h24;
    ctrl_rb = EN ? 8'h01 : 8'h00;

    //   name            rd wr addr  oe dout  txr rxv rxd    cd exp    hit txv txd   rxr irq
    add("rst_status",    1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h05, 1, 0, 8'h00, 1, 0);
    add("rd_off_z",      0, 0, 5'h1D, 1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 0);
    add("wr_hold1",      0, 1, 5'h1C, 1, 8'hA5, 0, 0, 8'h00, 1, 8'hA5, 1, 0, 8'h00, 1, 0);
    add("wr_hold2",      0, 1, 5'h1C, 1, 8'hA5, 0, 0, 8'h00, 1, 8'hA5, 1, 1, 8'hA5, 1, 0);
    add("wr_hold3",      0, 1, 5'h1C, 1, 8'hA5, 0, 0, 8'h00, 1, 8'hA5, 1, 1, 8'hA5, 1, 0);
    add("st_one_push",   1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h01, 1, 1, 8'hA5, 1, 0);
    add("tx_pop",        0, 0, 5'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 1, 0);
    add("tx_empty",      0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("w11",           0, 1, 5'h1C, 1, 8'h11, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    add("g1",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("w22",           0, 1, 5'h1C, 1, 8'h22, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 1, 0);
    add("g2",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("w33",           0, 1, 5'h1C, 1, 8'h33, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 1, 0);
    add("g3",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("w44",           0, 1, 5'h1C, 1, 8'h44, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 1, 0);
    add("g4",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("w55_drop",      0, 1, 5'h1C, 1, 8'h55, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 1, 0);
    add("g5",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("st_ovf",        1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h19, 1, 1, 8'h11, 1, 0);
    add("g6",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("ctrl_clr",      0, 1, 5'h1E, 1, 8'h80, 0, 0, 8'h00, 1, 8'h80, 1, 1, 8'h11, 1, 0);
    add("g7",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("st_ovf_clr",    1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h09, 1, 1, 8'h11, 1, 0);
    add("g8",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("drain11",       0, 0, 5'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 1, 0);
    add("drain22",       0, 0, 5'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h22, 1, 0);
    add("drain33",       0, 0, 5'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h33, 1, 0);
    add("drain44",       0, 0, 5'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h44, 1, 0);
    add("drained",       0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_push3c",     0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_push7e",     0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h7E, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rd3c_a",        1, 0, 5'h1C, 0, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 1, 0, 8'h00, 1, 0);
    add("rd3c_addrmove", 1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 1, 0, 8'h00, 1, 0);
    add("rd_fall_z",     0, 0, 5'h1C, 1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 0);
    add("rd7e",          1, 0, 5'h1C, 0, 8'h00, 0, 0, 8'h00, 1, 8'h7E, 1, 0, 8'h00, 1, 0);
    add("g9",            0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rd_udf",        1, 0, 5'h1C, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 0);
    add("g10",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("st_udf",        1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h25, 1, 0, 8'h00, 1, 0);
    add("g11",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rdwr_both",     1, 1, 5'h1D, 1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 0);
    add("g12",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("scr_wr",        0, 1, 5'h1F, 1, 8'h5A, 0, 0, 8'h00, 1, 8'h5A, 1, 0, 8'h00, 1, 0);
    add("g13",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("scr_rd",        1, 0, 5'h1F, 0, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 1, 0, 8'h00, 1, 0);
    add("miss_z",        1, 0, 5'h1B, 1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 0);
    add("g14",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("ctrl_ie",       0, 1, 5'h1E, 1, 8'h01, 0, 0, 8'h00, 1, 8'h01, 1, 0, 8'h00, 1, 0);
    add("g15",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("ctrl_rd",       1, 0, 5'h1E, 0, 8'h00, 0, 0, 8'h00, 1, ctrl_rb, 1, 0, 8'h00, 1, 0);
    add("irq_push",      0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h99, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("irq_lat",       0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("irq_st",        1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, st_irq, 1, 0, 8'h00, 1, EN);
    add("irq_hold",      0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, EN);
    add("irq_rd99",      1, 0, 5'h1C, 0, 8'h00, 0, 0, 8'h00, 1, 8'h99, 1, 0, 8'h00, 1, EN);
    add("irq_pop",       0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, EN);
    add("irq_fall_lat",  0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, EN);
    add("irq_fallen",    0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("ctrl_off",      0, 1, 5'h1E, 1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 1, 0);
    add("g16",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_fill1",      0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h01, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_fill2",      0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h02, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_fill3",      0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h03, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_fill4",      0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h04, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add("rx_full",       0, 0, 5'h00, 0, 8'h00, 0, 1, 8'h05, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add("st_rxfull",     1, 0, 5'h1D, 0, 8'h00, 0, 0, 8'h00, 1, 8'h26, 1, 0, 8'h00, 0, 0);
    add("g17",           0, 0, 5'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    rst = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 5'h00;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    cpu_oe = 1'b0; cpu_do = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset.tx_valid", {7'd0, bus.tx_valid}, 8'h00);
    chk("reset.tx_data", bus.tx_data, 8'h00);
    chk("reset.rx_ready", {7'd0, bus.rx_ready}, 8'h01);
    chk("reset.irq", {7'd0, irq}, 8'h00);
    tick();

    foreach (vecs[i]) apply(vecs[i]);

    // Reset arrives while a DATA read is in progress with RX holding 01..04.
    bus.rd = 1'b1; bus.addr = 5'h1C; cpu_oe = 1'b0;
    #1;
    chk("rst_mid.head", data, 8'h01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.rd = 1'b0; cpu_oe = 1'b1; cpu_do = 8'h00;
    #1;
    chk("rst_mid.data_z", data, 8'h00);
    chk("rst_mid.rx_ready", {7'd0, bus.rx_ready}, 8'h01);
    chk("rst_mid.tx_valid", {7'd0, bus.tx_valid}, 8'h00);
    chk("rst_mid.tx_data", bus.tx_data, 8'h00);
    chk("rst_mid.irq", {7'd0, irq}, 8'h00);
    tick();
    bus.rd = 1'b1; bus.addr = 5'h1D; cpu_oe = 1'b0;
    #1;
    chk("rst_mid.status", data, 8'h05);
    tick();
    bus.rd = 1'b0; bus.addr = 5'h1C;
    tick();
    bus.rd = 1'b1;
    #1;
    chk("rst_mid.rx_empty_read", data, 8'h00);
    tick();
    bus.rd = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O target on the CPU's shared `rd`/`wr`/`addr`/bidirectional `data` bus. It decodes a 4-address window at the top of the 5-bit address space and answers bus reads and writes in place of `single_bi_mem`. It bridges CPU stores into an outbound byte stream (TX FIFO) and an inbound byte stream (RX FIFO) into CPU loads. It sits beside the memory at the top level; `rd` and `wr` are gated so that the memory ignores window hits.

## Interface
- `A_WIDTH`, 5, bus address width
- `WIDTH`, 8, bus data width
- `BASE`, 5'h1C, window base; must be 4-aligned; window is BASE..BASE+3
- `DEPTH`, 4, entries per FIFO (power of two, ≥2)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd`  in  1  bus read strobe, may stay high for several cycles
- `wr`  in  1  bus write strobe, may stay high for several cycles
- `addr`  in  A_WIDTH  bus address
- `data`  inout  WIDTH  shared data bus; driven only while `rd` and window hit, else Z
- `hit`  out  1  combinational `addr` in window; top level gates memory `rd`/`wr` with it
- `tx_valid`  out  1  TX FIFO head valid
- `tx_data`  out  WIDTH  TX FIFO head
- `tx_ready`  in  1  sink accepts head this cycle
- `rx_valid`  in  1  source offers byte
- `rx_data`  in  WIDTH  offered byte
- `rx_ready`  out  1  = RX FIFO not full
- `irq`  out  1  registered interrupt request

## Operation
- Offsets: 0 DATA, 1 STATUS, 2 CTRL, 3 SCRATCH.
- DATA write: pushes `data` into the TX FIFO; if the FIFO is full the byte is dropped and sticky `tx_ovf` is set.
- DATA read: drives the RX FIFO head; if empty, drives 0 and sets sticky `rx_udf`.
- STATUS read: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_ovf, bit5 rx_udf, bit6 irq, bit7 0. Writes are ignored.
- CTRL: bit0 rx_ie, bit1 tx_ie, stored and read back in bits [1:0]; other bits read 0.
- CTRL write with bit7=1 clears `tx_ovf` and `rx_udf`; bit7 is not stored.
- SCRATCH: plain read/write register.
- Access FSM, per strobe: IDLE → ACTIVE on the first cycle the strobe is high with a hit. ACTIVE → IDLE when the strobe falls.
  - Write side effects (push, register update) occur once, on the IDLE→ACTIVE edge.
  - Read pop occurs once, on the edge where `rd` falls after a DATA-read ACTIVE period, so the read data holds for the whole `rd` window.
- `rd` and `wr` both high: `wr` wins; no data drive, no pop.
- `addr` change while ACTIVE: the access stays bound to the offset latched at entry.
- Stream side: TX pops when `tx_valid & tx_ready`; RX pushes when `rx_valid & rx_ready`.
- Same-cycle push and pop on one FIFO: both occur and the count is unchanged.
- Full checks use the registered count, so a CPU push into a full TX FIFO is dropped even if the stream pops that cycle.

## Timing
- Reset values:
  - FIFOs empty, `tx_valid` 0, `tx_data` 0, `rx_ready` 1.
  - CTRL 0, SCRATCH 0, sticky flags 0, `irq` 0.
  - FSM IDLE, `data` Z.
- Read data: combinational from `addr`/`rd`; valid in the same cycle.
- TX push visible on `tx_valid` 1 cycle after the write edge.
- RX byte readable 1 cycle after the push handshake.
- `irq` = registered ((rx_ie & !rx_empty) | (tx_ie & tx_empty)); 1-cycle latency from the state change.
- Reset mid-access drops any pending pop or push; the FSM returns to IDLE.

## Configuration
- `MMIO_IRQ_EN` defined: CTRL bits [1:0], STATUS bit6, and `irq` logic are present.
- `MMIO_IRQ_EN` undefined: `irq` is tied 0, CTRL reads 0 and CTRL writes affect only bit7 flag clearing, STATUS bit6 reads 0.

## Structure
- Package `mmio_pkg`: offset constants (OFF_DATA, OFF_STATUS, OFF_CTRL, OFF_SCRATCH), STATUS/CTRL bit-index constants, access-FSM state typedef.
- Sub-module `sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/count), instantiated for TX and RX.

## Test plan
- Reset, then read STATUS at 0x1D → 8'h05 (both FIFOs empty); `irq` 0, `rx_ready` 1.
- `wr` held 3 cycles at 0x1C with 8'hA5, `tx_ready` 0 → exactly one push: `tx_valid`=1, `tx_data`=A5. Then `tx_ready` 1 → `tx_valid` 0.
- Write 0x1C five times (DEPTH 4), `tx_ready` 0 → STATUS = 8'h19 (rx_empty, tx_full, tx_ovf). CTRL write 8'h80 → bit4 clears.
- Push 8'h3C and 8'h7E via rx handshake; `rd` held 2 cycles at 0x1C → bus reads 3C throughout, pop on `rd` fall; next read → 7E; third read → 0 with rx_udf set.
- CTRL=8'h01, push 1 RX byte → `irq` rises 1 cycle after the push; read DATA → `irq` falls 1 cycle after the pop.
- Assert `rst` while `rd` is high on DATA with RX non-empty → no pop, FIFOs empty, `data` Z the next cycle.
